// File: rtl/seq_alu.sv
// Registered W-bit ALU with a CZN flag register and a multi-cycle shift-add multiplier.
// Single-cycle ops return in one cycle; MUL iterates W cycles behind a start/busy/done handshake.
module seq_alu #(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   opcode,
  input  logic [W-1:0] alu_in1,
  input  logic [W-1:0] alu_in2,
  output logic [W-1:0] alu_out,
  output logic [W-1:0] alu_out_hi,
  output logic [2:0]   czn,
  output logic         busy,
  output logic         done
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MUL_RUN = 1'b1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  logic [0:0]     state;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] acc_nxt;
  logic [W:0]     ext;
  logic [W-1:0]   res;
  logic           c_nxt;

  assign busy = (state == MUL_RUN);

  // Arithmetic in W+1 bits: bit W is carry-out for adds and borrow for subtracts.
  always_comb begin
    ext   = '0;
    c_nxt = czn[0];
    case (opcode)
      OP_ADD: begin
        ext   = {1'b0, alu_in1} + {1'b0, alu_in2};
        c_nxt = ext[W];
      end
      OP_ADC: begin
        ext   = {1'b0, alu_in1} + {1'b0, alu_in2} + {{W{1'b0}}, czn[0]};
        c_nxt = ext[W];
      end
      OP_SUB: begin
        ext   = {1'b0, alu_in1} - {1'b0, alu_in2};
        c_nxt = ext[W];
      end
      OP_SBB: begin
        ext   = {1'b0, alu_in1} - {1'b0, alu_in2} - {{W{1'b0}}, czn[0]};
        c_nxt = ext[W];
      end
      OP_AND:  ext = {1'b0, alu_in1 & alu_in2};
      OP_OR:   ext = {1'b0, alu_in1 | alu_in2};
      OP_XOR:  ext = {1'b0, alu_in1 ^ alu_in2};
      default: ext = '0;
    endcase
    res = ext[W-1:0];
  end

  // Multiplicand shifts left and multiplier shifts right, so mul_b[0] is B[counter].
  assign acc_nxt = acc + (mul_b[0] ? mul_a : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      alu_out    <= '0;
      alu_out_hi <= '0;
      czn        <= 3'b000;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (opcode == OP_MUL) begin
            mul_a <= {{W{1'b0}}, alu_in1};
            mul_b <= alu_in2;
            acc   <= '0;
            cnt   <= '0;
            state <= MUL_RUN;
          end else begin
            alu_out    <= res;
            alu_out_hi <= '0;
            czn        <= {res[W-1], (res == '0), c_nxt};
            done       <= 1'b1;
          end
        end
      end else begin
        acc   <= acc_nxt;
        mul_a <= mul_a << 1;
        mul_b <= mul_b >> 1;
        cnt   <= cnt + 1'b1;
        if (cnt == CW'(W - 1)) begin
          alu_out    <= acc_nxt[W-1:0];
          alu_out_hi <= acc_nxt[2*W-1:W];
          czn        <= {acc_nxt[W-1], (acc_nxt == '0), (acc_nxt[2*W-1:W] != '0)};
          done       <= 1'b1;
          state      <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (W=8): directed vectors push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] opcode;
  logic [7:0] alu_in1, alu_in2;
  logic [7:0] alu_out, alu_out_hi;
  logic [2:0] czn;
  logic       busy, done;

  typedef struct {
    logic [7:0] o;
    logic [7:0] hi;
    logic [2:0] f;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   stray_done;

  seq_alu #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_out_hi(alu_out_hi), .czn(czn),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Apply start for exactly one rising edge; optionally record the expected result.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit push, input logic [7:0] eo, input logic [7:0] ehi,
                       input logic [2:0] ef);
    exp_t e;
    start = 1'b1; opcode = op; alu_in1 = a; alu_in2 = b;
    if (push) begin
      e.o = eo; e.hi = ehi; e.f = ef;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    alu_in1 = $urandom_range(255);
    alu_in2 = $urandom_range(255);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("alu_out", {8'h00, alu_out}, {8'h00, e.o});
        chk("alu_out_hi", {8'h00, alu_out_hi}, {8'h00, e.hi});
        chk("czn", {13'h0, czn}, {13'h0, e.f});
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; opcode = '0; alu_in1 = '0; alu_in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {alu_out_hi, alu_out}, 16'h0000);
    chk("rst_flags", {11'h0, czn, busy, done}, 16'h0000);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Carry out, then ADC consumes it.
    issue(3'd0, 8'hFF, 8'h01, 1, 8'h00, 8'h00, 3'b011);
    issue(3'd1, 8'h10, 8'h20, 1, 8'h31, 8'h00, 3'b000);

    // Reset mid-MUL: outputs clear asynchronously, no done afterwards.
    issue(3'd0, 8'hFF, 8'h01, 1, 8'h00, 8'h00, 3'b011);
    issue(3'd7, 8'h0F, 8'h0F, 0, 8'h00, 8'h00, 3'b000);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", {alu_out_hi, alu_out}, 16'h0000);
    chk("async_rst_flags", {11'h0, czn, busy, done}, 16'h0000);
    @(negedge clk); rst = 1'b0;
    stray_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) stray_done++;
    end
    chk("no_done_after_abort", 16'(stray_done), 16'd0);
    @(negedge clk);
    issue(3'd0, 8'h03, 8'h04, 1, 8'h07, 8'h00, 3'b000);

    // Borrow, then SBB consumes it; SBB borrow at the W+1-bit boundary.
    issue(3'd2, 8'h05, 8'h07, 1, 8'hFE, 8'h00, 3'b101);
    issue(3'd3, 8'h10, 8'h01, 1, 8'h0E, 8'h00, 3'b000);
    issue(3'd0, 8'hFF, 8'h01, 1, 8'h00, 8'h00, 3'b011);
    issue(3'd3, 8'h00, 8'hFF, 1, 8'h00, 8'h00, 3'b011);

    // Logic ops keep C.
    issue(3'd0, 8'h80, 8'h80, 1, 8'h00, 8'h00, 3'b011);
    issue(3'd6, 8'hAA, 8'hAA, 1, 8'h00, 8'h00, 3'b011);
    issue(3'd5, 8'h80, 8'h01, 1, 8'h81, 8'h00, 3'b101);

    // MUL timing: busy after edges k..k+7, done after edge k+8, starts ignored while busy.
    issue(3'd7, 8'hFF, 8'hFF, 1, 8'h01, 8'hFE, 3'b001);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mul_busy", {15'h0, busy}, 16'h0001);
      chk("mul_done_low", {15'h0, done}, 16'h0000);
      if (i == 2) begin start = 1'b1; opcode = 3'd0; alu_in1 = 8'h11; alu_in2 = 8'h22; end
      if (i == 4) start = 1'b0;
    end
    @(negedge clk);
    chk("mul_busy_end", {15'h0, busy}, 16'h0000);
    chk("mul_done_pulse", {15'h0, done}, 16'h0001);
    @(negedge clk);
    chk("mul_done_once", {15'h0, done}, 16'h0000);

    // More MUL flag cases.
    issue(3'd7, 8'h0C, 8'h0A, 1, 8'h78, 8'h00, 3'b000);
    repeat (9) @(negedge clk);
    issue(3'd7, 8'h10, 8'h08, 1, 8'h80, 8'h00, 3'b100);
    repeat (9) @(negedge clk);

    // Back-to-back starts on consecutive edges.
    issue(3'd0, 8'h01, 8'h01, 1, 8'h02, 8'h00, 3'b000);
    issue(3'd4, 8'h0F, 8'h3C, 1, 8'h0C, 8'h00, 3'b000);
    issue(3'd7, 8'h00, 8'h55, 1, 8'h00, 8'h00, 3'b010);

    begin
      int budget;
      budget = 50;
      while (q.size() != 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      #1;
      chk("scoreboard_drained", 16'(q.size()), 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU, sitting in the datapath between the register file and write-back.
- Adds width parameter W, 3-bit opcode with carry-chained ops (ADC/SBB), subtraction with borrow, XOR, and a multi-cycle shift-add multiplier.
- Holds an internal CZN flag register and uses a start/busy/done handshake toward the controller.

Parameters:
- W, 8, operand and result width in bits (W >= 2).
- CW, $clog2(W)+1, width of the multiply iteration counter (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to execute opcode on alu_in1/alu_in2; sampled on rising edge.
- opcode  input  3  0 ADD, 1 ADC, 2 SUB, 3 SBB, 4 AND, 5 OR, 6 XOR, 7 MUL.
- alu_in1  input  W  operand A (unsigned for C, two's complement for N).
- alu_in2  input  W  operand B.
- alu_out  output  W  registered result; MUL low half.
- alu_out_hi  output  W  registered MUL high half; zero after any non-MUL op.
- czn  output  3  flag register: [0] C, [1] Z, [2] N.
- busy  output  1  high while MUL iterates; start ignored when high.
- done  output  1  one-cycle pulse when alu_out/czn hold a new result.

Behaviour:
- Reset (async, any state): alu_out=0, alu_out_hi=0, czn=3'b000, busy=0, done=0, counter=0, FSM=IDLE. Reset during MUL aborts it; no done pulse afterward.
- FSM states: IDLE, MUL_RUN.
- Accept: rising edge with start=1 and busy=0. Edge with start=1 and busy=1 is ignored; no queuing.
- done defaults to 0 each cycle. Set to 1 only on the edge that writes a result, for exactly one cycle.
- Single-cycle ops (0-6), accepted at edge k:
  - alu_out, alu_out_hi=0 and czn are written at edge k.
  - done=1 during cycle k+1. FSM stays IDLE; back-to-back starts give one result per cycle.
- Arithmetic is computed in W+1 bits:
  - ADD: A+B, C=carry out.
  - ADC: A+B+C_old, C=carry out.
  - SUB: A-B, C=borrow (1 iff A<B unsigned).
  - SBB: A-B-C_old, C=borrow (1 iff A < B+C_old, evaluated in W+1 bits).
- Logic ops (AND/OR/XOR): C preserved (unchanged from its previous value).
- Z=1 iff the W-bit result is 0. N = result[W-1] (MSB, not a signed compare).
- MUL (opcode 7), accepted at edge k:
  - Edge k: latch A and B, clear a 2W-bit accumulator, counter=0, busy=1, FSM=MUL_RUN. alu_out/czn unchanged.
  - Each following edge: if B[counter]=1, add A<<counter to the accumulator; counter++.
  - On the edge completing iteration W-1 (edge k+W): alu_out=acc[W-1:0], alu_out_hi=acc[2W-1:W], busy=0, done=1 next cycle, FSM=IDLE.
  - Flags: C=1 iff alu_out_hi != 0. Z=1 iff the full 2W product is 0. N=acc[W-1].
- Operand inputs may change freely after accept; MUL uses its latched copies.
- Flag register is written only on result edges; it holds its value otherwise.

Test Plan:
- Reset mid-MUL: W=8, start MUL 15*15, assert rst after 3 cycles -> all outputs 0 immediately (async), no done pulse, next ADD works normally.
- ADD carry: ADD 0xFF+0x01 -> alu_out=0x00, czn=3'b011 (C=1, Z=1, N=0), done one cycle after accept. Then ADC 0x10+0x20 -> 0x31, czn=3'b000.
- SUB borrow: SUB 0x05-0x07 -> alu_out=0xFE, czn=3'b101. Then SBB 0x10-0x01 -> 0x0E, C=0, Z=0, N=0.
- Logic preserves carry: set C=1 via ADD 0x80+0x80 -> 0x00, czn=3'b011. Then XOR 0xAA^0xAA -> 0x00, czn=3'b011. Then OR 0x80|0x01 -> 0x81, czn=3'b101.
- MUL timing: MUL 0xFF*0xFF accepted at edge k -> busy=1 for edges k..k+7, result at edge k+8: alu_out=0x01, alu_out_hi=0xFE, czn=3'b001, done high exactly one cycle. start pulses while busy are ignored.
- Back-to-back: ADD 1+1, AND 0x0F&0x3C, MUL 0*0x55 on consecutive cycles -> 0x02 and 0x0C on consecutive done pulses. MUL completes 8 edges later with alu_out=0, alu_out_hi=0, czn=3'b010.
